snoop_bus_arbiter: RTL

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for a four-core snoop bus: grants one requester, broadcasts
// its command and address, collects snoop acks/shared status, then signals completion.
module snoop_bus_arbiter #(
  parameter int ADDRESSSIZE   = 32,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               Bus_Req,
  input  logic [7:0]               Bus_Op,
  input  logic [4*ADDRESSSIZE-1:0] Address_Req,
  input  logic [3:0]               Snoop_Ack,
  input  logic [3:0]               Shared_In,
  output logic [3:0]               Bus_Grant,
  output logic                     BusRd,
  output logic                     BusRdX,
  output logic                     Invalidate,
  output logic [ADDRESSSIZE-1:0]   Address_Com,
  output logic                     Shared,
  output logic [3:0]               Bus_Done,
  output logic                     Snoop_Timeout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BROADCAST = 2'd1;
  localparam logic [1:0] SNOOP     = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RDX = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam int CW = (SNOOP_TIMEOUT < 1) ? 1 : $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(SNOOP_TIMEOUT);

  logic [1:0]             state;
  logic [1:0]             last_grant;
  logic [1:0]             win;
  logic [1:0]             op;
  logic [CW-1:0]          cnt;
  logic [3:0]             ack_sticky;
  logic                   shared_sticky;

  logic [1:0]             req_op   [4];
  logic [ADDRESSSIZE-1:0] req_addr [4];
  logic [3:0]             eligible;
  logic                   found;
  logic [1:0]             win_idx;
  logic [1:0]             idx;
  logic [3:0]             ack_next;
  logic                   shared_next;
  logic                   all_acked;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_op[i]   = Bus_Op[2*i +: 2];
      req_addr[i] = Address_Req[i*ADDRESSSIZE +: ADDRESSSIZE];
      eligible[i] = Bus_Req[i] && (req_op[i] != 2'b00);
    end
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    found   = 1'b0;
    win_idx = last_grant;
    idx     = last_grant;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  // The winner's own ack and shared line are masked out; acks this cycle count.
  always_comb begin
    ack_next    = ack_sticky | (Snoop_Ack & ~Bus_Grant);
    shared_next = shared_sticky | (|(Snoop_Ack & Shared_In & ~Bus_Grant));
    all_acked   = &(ack_next | Bus_Grant);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 2'd3;
      win           <= 2'd0;
      op            <= 2'b00;
      cnt           <= '0;
      ack_sticky    <= 4'b0000;
      shared_sticky <= 1'b0;
      Bus_Grant     <= 4'b0000;
      BusRd         <= 1'b0;
      BusRdX        <= 1'b0;
      Invalidate    <= 1'b0;
      Address_Com   <= '0;
      Shared        <= 1'b0;
      Bus_Done      <= 4'b0000;
      Snoop_Timeout <= 1'b0;
    end else begin
      Bus_Done      <= 4'b0000;
      Shared        <= 1'b0;
      Snoop_Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            win         <= win_idx;
            op          <= req_op[win_idx];
            Bus_Grant   <= 4'b0001 << win_idx;
            BusRd       <= (req_op[win_idx] == OP_RD);
            BusRdX      <= (req_op[win_idx] == OP_RDX);
            Invalidate  <= (req_op[win_idx] == OP_INV);
            Address_Com <= req_addr[win_idx];
            state       <= BROADCAST;
          end else begin
            Bus_Grant <= 4'b0000;
          end
        end
        BROADCAST: begin
          cnt           <= '0;
          ack_sticky    <= 4'b0000;
          shared_sticky <= 1'b0;
          state         <= SNOOP;
        end
        SNOOP: begin
          ack_sticky    <= ack_next;
          shared_sticky <= shared_next;
          if (all_acked || cnt == CNT_LIMIT) begin
            BusRd         <= 1'b0;
            BusRdX        <= 1'b0;
            Invalidate    <= 1'b0;
            Bus_Done      <= Bus_Grant;
            Shared        <= (op == OP_RD) && shared_next;
            Snoop_Timeout <= !all_acked;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          last_grant    <= win;
          ack_sticky    <= 4'b0000;
          shared_sticky <= 1'b0;
          Bus_Grant     <= 4'b0000;
          Address_Com   <= '0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
